// File: rtl/micro_const_pkg.sv
// Shared micro-architecture constants: ALU opcodes and the Fibonacci sequencer state type.
package micro_const_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } fib_state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU; second operand is either a register or the immediate (alusrc=1).
module alu
  import micro_const_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] reg_source1,
  input  logic [N-1:0] reg_source2,
  input  logic [N-1:0] immg_source,
  input  logic         alusrc,
  input  logic [3:0]   instruction,
  output logic [N-1:0] reg_destiny
);

  logic [N-1:0] w_op2;

  assign w_op2 = alusrc ? immg_source : reg_source2;

  always_comb begin
    reg_destiny = '0;
    case (instruction)
      ALU_AND:  reg_destiny = reg_source1 & w_op2;
      ALU_OR:   reg_destiny = reg_source1 | w_op2;
      ALU_ADD:  reg_destiny = reg_source1 + w_op2;
      ALU_SUB:  reg_destiny = reg_source1 - w_op2;
      ALU_SLT:  reg_destiny = N'($signed(reg_source1) < $signed(w_op2));
      ALU_SLTU: reg_destiny = N'(reg_source1 < w_op2);
      default:  reg_destiny = '0;
    endcase
  end

endmodule

// File: rtl/alu_fib_sequencer.sv
// Multi-cycle controller computing fib(n) through an external ALU with a start/busy/done handshake.
// Optional ALU_FIB_OVF_CHECK_EN: adds a CMP state using ALU_SLTU to flag unsigned wrap (sticky overflow_o).
module alu_fib_sequencer
  import micro_const_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CNT_W-1:0] n_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [N-1:0]     result_o,
  output logic             overflow_o,
  output logic [N-1:0]     alu_rs1_o,
  output logic [N-1:0]     alu_rs2_o,
  output logic [N-1:0]     alu_imm_o,
  output logic             alu_alusrc_o,
  output logic [3:0]       alu_instr_o,
  input  logic [N-1:0]     alu_rd_i
);

  fib_state_t       r_state;
  logic [N-1:0]     r_a;
  logic [N-1:0]     r_b;
  logic [CNT_W-1:0] r_cnt;
`ifdef ALU_FIB_OVF_CHECK_EN
  logic [N-1:0]     r_sum_q;
  logic             r_overflow;
`endif

  assign busy_o       = (r_state != IDLE);
  assign done_o       = (r_state == DONE);
  assign alu_imm_o    = '0;
  assign alu_alusrc_o = 1'b0;
`ifdef ALU_FIB_OVF_CHECK_EN
  assign overflow_o   = r_overflow;
`else
  assign overflow_o   = 1'b0;
`endif

  always_comb begin
    alu_instr_o = ALU_ADD;
    alu_rs1_o   = '0;
    alu_rs2_o   = '0;
    case (r_state)
      ADD: begin
        alu_rs1_o = r_a;
        alu_rs2_o = r_b;
      end
`ifdef ALU_FIB_OVF_CHECK_EN
      // sum < b exactly when a + b wrapped past 2^N-1
      CMP: begin
        alu_instr_o = ALU_SLTU;
        alu_rs1_o   = r_sum_q;
        alu_rs2_o   = r_b;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_cnt      <= '0;
      result_o   <= '0;
`ifdef ALU_FIB_OVF_CHECK_EN
      r_sum_q    <= '0;
      r_overflow <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_a   <= '0;
            r_b   <= N'(1);
            r_cnt <= n_i;
`ifdef ALU_FIB_OVF_CHECK_EN
            r_overflow <= 1'b0;
`endif
            if (n_i == '0) begin
              result_o <= '0;
              r_state  <= DONE;
            end else if (n_i == CNT_W'(1)) begin
              result_o <= N'(1);
              r_state  <= DONE;
            end else begin
              r_state <= ADD;
            end
          end
        end
        ADD: begin
`ifdef ALU_FIB_OVF_CHECK_EN
          r_sum_q <= alu_rd_i;
          r_state <= CMP;
`else
          r_a   <= r_b;
          r_b   <= alu_rd_i;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(2)) begin
            result_o <= alu_rd_i;
            r_state  <= DONE;
          end
`endif
        end
`ifdef ALU_FIB_OVF_CHECK_EN
        CMP: begin
          r_overflow <= r_overflow | alu_rd_i[0];
          r_a        <= r_b;
          r_b        <= r_sum_q;
          r_cnt      <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(2)) begin
            result_o <= r_sum_q;
            r_state  <= DONE;
          end else begin
            r_state <= ADD;
          end
        end
`endif
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_fib_sequencer.sv
// Self-checking bench: directed table, randomized runs against an arithmetic Fibonacci model, and corner sequences.
module tb_alu_fib_sequencer;
  import micro_const_pkg::*;

  localparam int N     = 32;
  localparam int CNT_W = 6;
`ifdef ALU_FIB_OVF_CHECK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start_i;
  logic [CNT_W-1:0] n_i;
  logic             busy_o, done_o, overflow_o, alu_alusrc;
  logic [N-1:0]     result_o, alu_rs1, alu_rs2, alu_imm, alu_rd;
  logic [3:0]       alu_instr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_fib_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .n_i(n_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .overflow_o(overflow_o),
    .alu_rs1_o(alu_rs1), .alu_rs2_o(alu_rs2), .alu_imm_o(alu_imm),
    .alu_alusrc_o(alu_alusrc), .alu_instr_o(alu_instr), .alu_rd_i(alu_rd)
  );

  alu #(.N(N)) u_alu (
    .reg_source1(alu_rs1), .reg_source2(alu_rs2), .immg_source(alu_imm),
    .alusrc(alu_alusrc), .instruction(alu_instr), .reg_destiny(alu_rd)
  );

  typedef struct {
    int          n;
    logic [31:0] res;
    bit          ovf;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: plain iterative Fibonacci in 64-bit, reducing mod 2^32 and noting any carry out.
  function automatic void fib_model(input int n, output logic [31:0] r, output bit ovf);
    longint unsigned a, b, s;
    a = 0; b = 1; ovf = 1'b0;
    if (n == 0) begin
      r = 32'd0;
      return;
    end
    for (int k = 2; k <= n; k++) begin
      s = a + b;
      if (s > 64'hFFFF_FFFF) ovf = 1'b1;
      a = b;
      b = s & 64'hFFFF_FFFF;
    end
    r = b[31:0];
  endfunction

  function automatic int exp_lat(input int n);
    if (n < 2) return 1;
    return OVF_EN ? 2 * (n - 1) + 1 : n;
  endfunction

  task automatic run_and_check(input string tag, input int n, input logic [31:0] er,
                               input bit eovf, input int inject_at);
    int lat, bad_busy, bad_instr, extra_done;
    logic [3:0] ei;
    bad_busy = 0; bad_instr = 0; extra_done = 0;
    @(negedge clk);
    start_i = 1'b1;
    n_i     = CNT_W'(n);
    @(negedge clk);
    start_i = 1'b0;
    n_i     = CNT_W'($urandom);
    lat = 1;
    while (!done_o && lat < 200) begin
      if (!busy_o) bad_busy++;
      ei = (OVF_EN && (lat % 2 == 0)) ? ALU_SLTU : ALU_ADD;
      if (alu_instr !== ei) bad_instr++;
      if (lat == inject_at) begin
        start_i = 1'b1;
        n_i     = CNT_W'(3);
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start_i = 1'b0;
    chk({tag, " latency"}, lat, exp_lat(n));
    chk({tag, " busy_at_done"}, busy_o, 1);
    chk({tag, " result"}, result_o, er);
    chk({tag, " overflow"}, overflow_o, eovf & OVF_EN);
    chk({tag, " busy_during_run_errs"}, bad_busy, 0);
    chk({tag, " instr_seq_errs"}, bad_instr, 0);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, done_o, 0);
    chk({tag, " idle_after_done"}, busy_o, 0);
    chk({tag, " result_held"}, result_o, er);
    if (inject_at > 0) begin
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (done_o) extra_done++;
      end
      chk({tag, " extra_done_pulses"}, extra_done, 0);
    end
  endtask

  initial begin
    logic [31:0] mr;
    bit          mo;
    int          rn, seen_done;

    tbl[0] = '{n: 0,  res: 32'd0,          ovf: 1'b0};
    tbl[1] = '{n: 1,  res: 32'd1,          ovf: 1'b0};
    tbl[2] = '{n: 2,  res: 32'd1,          ovf: 1'b0};
    tbl[3] = '{n: 3,  res: 32'd2,          ovf: 1'b0};
    tbl[4] = '{n: 10, res: 32'd55,         ovf: 1'b0};
    tbl[5] = '{n: 47, res: 32'd2971215073, ovf: 1'b0};
    tbl[6] = '{n: 48, res: 32'd512559680,  ovf: 1'b1};

    rst_n = 1'b0; start_i = 1'b0; n_i = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", busy_o, 0);
    chk("reset done", done_o, 0);
    chk("reset result", result_o, 0);
    chk("reset overflow", overflow_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_and_check($sformatf("tbl_n%0d", tbl[i].n), tbl[i].n, tbl[i].res, tbl[i].ovf, 0);

    // start pulse with n=3 while a run at n=10 is in flight must be ignored
    run_and_check("ignore_start", 10, 32'd55, 1'b0, 4);

    for (int i = 0; i < 20; i++) begin
      rn = int'($urandom_range(0, 63));
      fib_model(rn, mr, mo);
      run_and_check($sformatf("rand%0d_n%0d", i, rn), rn, mr, mo, 0);
    end

    // asynchronous reset mid-run
    @(negedge clk);
    start_i = 1'b1; n_i = CNT_W'(20);
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrun busy_before_reset", busy_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_reset busy", busy_o, 0);
    chk("midrun_reset done", done_o, 0);
    chk("midrun_reset result", result_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o || busy_o) seen_done++;
    end
    chk("midrun_reset no_activity", seen_done, 0);
    run_and_check("after_reset_n5", 5, 32'd5, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
